// File: rtl/aead_poly_block_sequencer.sv
// Purpose: packs AAD and payload byte-keep streams into zero-padded 128-bit
// hash blocks for Poly1305/GHASH, counts section lengths and appends the
// final length block in ChaCha20-Poly1305 or GCM layout.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, algo_sel            begin/abort message, latch algorithm (1 = ChaCha)
//   aad_* / pld_*              input beat streams (valid/data/keep/last/ready)
//   blk_valid/data/kind/last   output block register, held until blk_ready
//   blk_ready                  downstream accept
//   aad_len, pld_len           section byte counters
//   busy, done, err            status: in message, LEN accepted, protocol error
module aead_poly_block_sequencer #(
   parameter int unsigned IN_W  = 128,
   parameter int unsigned LEN_W = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                algo_sel,
   input  logic                aad_valid,
   input  logic [IN_W-1:0]     aad_data,
   input  logic [IN_W/8-1:0]   aad_keep,
   input  logic                aad_last,
   output logic                aad_ready,
   input  logic                pld_valid,
   input  logic [IN_W-1:0]     pld_data,
   input  logic [IN_W/8-1:0]   pld_keep,
   input  logic                pld_last,
   output logic                pld_ready,
   output logic                blk_valid,
   output logic [127:0]        blk_data,
   output logic [1:0]          blk_kind,
   output logic                blk_last,
   input  logic                blk_ready,
   output logic [LEN_W-1:0]    aad_len,
   output logic [LEN_W-1:0]    pld_len,
   output logic                busy,
   output logic                done,
   output logic                err
);

   localparam int unsigned NB = IN_W / 8;
   localparam int unsigned CW = $clog2(NB + 1);
   localparam logic [1:0]  KIND_AAD = 2'd0;
   localparam logic [1:0]  KIND_PLD = 2'd1;
   localparam logic [1:0]  KIND_LEN = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_AAD  = 3'd1,
      S_PLD  = 3'd2,
      S_LEN  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t           state, state_nxt;
   logic             algo;
   logic [127:0]     acc;
   logic [4:0]       fill;

   logic             in_aad, in_pld, out_free;
   logic             sec_valid, sec_last, sec_fire;
   logic [IN_W-1:0]  sec_data;
   logic [NB-1:0]    sec_keep;
   logic [1:0]       sec_kind;
   logic [LEN_W-1:0] sec_len;
   logic [CW-1:0]    cnt;
   logic [NB:0]      keep_inc;
   logic             keep_bad;
   logic [127:0]     packed_blk;
   logic [4:0]       fill_sum;
   logic             emit;
   logic [LEN_W:0]   len_sum;
   logic             len_load, len_done;
   logic [63:0]      a64, p64;
   logic [127:0]     len_blk;

   // Reverse byte order of a 64-bit word (big-endian GCM length fields).
   function automatic logic [63:0] bswap64(input logic [63:0] x);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) r[8*i +: 8] = x[56-8*i +: 8];
      return r;
   endfunction

   // Section select, beat validation, packing and length-block construction.
   always_comb begin
      in_aad    = (state == S_AAD);
      in_pld    = (state == S_PLD);
      out_free  = !blk_valid || blk_ready;
      sec_valid = in_pld ? pld_valid : aad_valid;
      sec_last  = in_pld ? pld_last  : aad_last;
      sec_data  = in_pld ? pld_data  : aad_data;
      sec_keep  = in_pld ? pld_keep  : aad_keep;
      sec_kind  = in_pld ? KIND_PLD  : KIND_AAD;
      sec_len   = in_pld ? pld_len   : aad_len;
      // start blocks acceptance so no beat is consumed in an aborting cycle
      sec_fire  = sec_valid && (in_aad || in_pld) && out_free && !start;

      cnt = '0;
      for (int i = 0; i < int'(NB); i++) cnt = cnt + CW'(sec_keep[i]);

      // keep is contiguous from lane 0 iff keep & (keep+1) has no set bits
      keep_inc = {1'b0, sec_keep} + (NB+1)'(1);
      keep_bad = ((sec_keep & keep_inc[NB-1:0]) != '0) ||
                 (!sec_last && (sec_keep != '1));

      packed_blk = acc;
      for (int b = 0; b < 16; b++) begin
         for (int l = 0; l < int'(NB); l++) begin
            if (sec_keep[l] && (int'(fill) + l == b)) packed_blk[8*b +: 8] = sec_data[8*l +: 8];
         end
      end
      fill_sum = fill + 5'(cnt);
      emit     = (fill_sum == 5'd16) || (sec_last && (fill_sum != 5'd0));
      len_sum  = {1'b0, sec_len} + (LEN_W+1)'(cnt);

      // blk_last marks that the LEN block has already been loaded
      len_load = (state == S_LEN) && !blk_last && out_free && !start;
      len_done = (state == S_LEN) && blk_valid && blk_last && blk_ready;

      a64 = 64'(aad_len);
      p64 = 64'(pld_len);
      if (algo) len_blk = {p64, a64};
      else      len_blk = {bswap64({p64[60:0], 3'b000}), bswap64({a64[60:0], 3'b000})};
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; start wins in every state.
   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = S_AAD;
      end else begin
         case (state)
            S_AAD:   if (sec_fire && sec_last) state_nxt = S_PLD;
            S_PLD:   if (sec_fire && sec_last) state_nxt = S_LEN;
            S_LEN:   if (len_done)             state_nxt = S_DONE;
            default: state_nxt = state;
         endcase
      end
   end

   // Handshake and status outputs decoded from state.
   always_comb begin
      aad_ready = 1'b0;
      pld_ready = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      aad_ready = (state == S_AAD) && out_free && !start;
      pld_ready = (state == S_PLD) && out_free && !start;
      busy      = (state == S_AAD) || (state == S_PLD) || (state == S_LEN);
      done      = (state == S_DONE);
   end

   // Accumulator, counters, error flag and output block register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         algo      <= 1'b0;
         acc       <= '0;
         fill      <= '0;
         aad_len   <= '0;
         pld_len   <= '0;
         err       <= 1'b0;
         blk_valid <= 1'b0;
         blk_data  <= '0;
         blk_kind  <= '0;
         blk_last  <= 1'b0;
      end else if (start) begin
         algo      <= algo_sel;
         acc       <= '0;
         fill      <= '0;
         aad_len   <= '0;
         pld_len   <= '0;
         err       <= 1'b0;
         blk_valid <= 1'b0;
         blk_data  <= '0;
         blk_kind  <= '0;
         blk_last  <= 1'b0;
      end else begin
         if (blk_valid && blk_ready) blk_valid <= 1'b0;
         if (sec_fire) begin
            if (keep_bad) begin
               // discard the beat; a bad last beat still closes the section
               err <= 1'b1;
               if (sec_last) begin
                  acc  <= '0;
                  fill <= '0;
                  if (fill != 5'd0) begin
                     blk_valid <= 1'b1;
                     blk_data  <= acc;
                     blk_kind  <= sec_kind;
                     blk_last  <= 1'b0;
                  end
               end
            end else begin
               if (in_pld) pld_len <= len_sum[LEN_W-1:0];
               else        aad_len <= len_sum[LEN_W-1:0];
               if (len_sum[LEN_W]) err <= 1'b1;
               if (emit) begin
                  blk_valid <= 1'b1;
                  blk_data  <= packed_blk;
                  blk_kind  <= sec_kind;
                  blk_last  <= 1'b0;
               end
               if (emit || sec_last) begin
                  acc  <= '0;
                  fill <= '0;
               end else begin
                  acc  <= packed_blk;
                  fill <= fill_sum;
               end
            end
         end
         if (len_load) begin
            blk_valid <= 1'b1;
            blk_data  <= len_blk;
            blk_kind  <= KIND_LEN;
            blk_last  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_aead_poly_block_sequencer.sv
// Purpose: randomized self-checking bench for aead_poly_block_sequencer
// (IN_W=32, LEN_W=16). A byte-level model chunks each section into 16-byte
// zero-padded blocks and formats the length block; one compare process checks
// every accepted block, output stability while stalled and ready gating.
module tb_aead_poly_block_sequencer;

   localparam int unsigned IN_W  = 32;
   localparam int unsigned LEN_W = 16;
   localparam int unsigned NB    = IN_W / 8;

   typedef struct packed {
      logic [127:0] data;
      logic [1:0]   kind;
      logic         last;
   } blk_t;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } beat_t;

   typedef logic [7:0] byte_q_t [$];
   typedef beat_t      beat_q_t [$];

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start, algo_sel;
   logic             aad_valid, aad_last, aad_ready;
   logic [IN_W-1:0]  aad_data;
   logic [NB-1:0]    aad_keep;
   logic             pld_valid, pld_last, pld_ready;
   logic [IN_W-1:0]  pld_data;
   logic [NB-1:0]    pld_keep;
   logic             blk_valid, blk_last, blk_ready;
   logic [127:0]     blk_data;
   logic [1:0]       blk_kind;
   logic [LEN_W-1:0] aad_len, pld_len;
   logic             busy, done, err;

   int           checks = 0;
   int           failures = 0;
   int           blk_count = 0;
   logic [127:0] last_len = '0;
   int           rdy_mode = 0;
   int           stall_cnt = 0;
   bit           gaps = 1'b0;
   blk_t         exp_q [$];

   always #5 clk = ~clk;

   aead_poly_block_sequencer #(.IN_W(IN_W), .LEN_W(LEN_W)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .algo_sel(algo_sel),
      .aad_valid(aad_valid), .aad_data(aad_data), .aad_keep(aad_keep),
      .aad_last(aad_last), .aad_ready(aad_ready),
      .pld_valid(pld_valid), .pld_data(pld_data), .pld_keep(pld_keep),
      .pld_last(pld_last), .pld_ready(pld_ready),
      .blk_valid(blk_valid), .blk_data(blk_data), .blk_kind(blk_kind),
      .blk_last(blk_last), .blk_ready(blk_ready),
      .aad_len(aad_len), .pld_len(pld_len),
      .busy(busy), .done(done), .err(err)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Length block from the byte counts.
   function automatic logic [127:0] len_model(input bit algo, input logic [LEN_W-1:0] a,
                                              input logic [LEN_W-1:0] p);
      logic [63:0] a64, p64, ar, pr;
      a64 = 64'(a);
      p64 = 64'(p);
      if (algo) return {p64, a64};
      a64 = a64 * 64'd8;
      p64 = p64 * 64'd8;
      ar = {<<8{a64}};
      pr = {<<8{p64}};
      return {pr, ar};
   endfunction

   // Section bytes cut into 16-byte blocks, tail zero-padded.
   task automatic push_blocks(input byte_q_t by, input logic [1:0] kind);
      blk_t e;
      for (int i = 0; i < by.size(); i += 16) begin
         e.data = '0;
         for (int j = 0; j < 16; j++) if (i + j < by.size()) e.data[8*j +: 8] = by[i+j];
         e.kind = kind;
         e.last = 1'b0;
         exp_q.push_back(e);
      end
   endtask

   // Random section of n good bytes, optionally with one bad non-last beat inserted.
   task automatic gen_section(input int n, input int bad_keep, output beat_q_t bq, output byte_q_t by);
      int          nfull, rem;
      logic [31:0] d;
      beat_t       bt;
      bq = {};
      by = {};
      for (int i = 0; i < n; i++) by.push_back(8'($urandom));
      nfull = n / 4;
      rem   = n % 4;
      for (int f = 0; f < nfull; f++) begin
         d = {by[4*f+3], by[4*f+2], by[4*f+1], by[4*f]};
         bq.push_back({d, 4'hF, 1'b0});
      end
      if (rem > 0) begin
         d = $urandom;
         for (int j = 0; j < rem; j++) d[8*j +: 8] = by[4*nfull+j];
         bq.push_back({d, 4'((1 << rem) - 1), 1'b1});
      end else if (nfull > 0 && $urandom_range(0, 1) == 1) begin
         bt = bq.pop_back();
         bt.last = 1'b1;
         bq.push_back(bt);
      end else begin
         bq.push_back({32'($urandom), 4'h0, 1'b1});
      end
      if (bad_keep >= 0) bq.insert($urandom_range(0, bq.size() - 1), {32'($urandom), 4'(bad_keep), 1'b0});
   endtask

   task automatic drive_ready();
      case (rdy_mode)
         0: blk_ready = 1'b1;
         1: blk_ready = ($urandom_range(0, 3) != 0);
         2: if (blk_valid && stall_cnt < 3) begin
               blk_ready = 1'b0;
               stall_cnt++;
            end else blk_ready = 1'b1;
         default: blk_ready = 1'b0;
      endcase
   endtask

   task automatic idle();
      aad_valid = 1'b0;
      pld_valid = 1'b0;
      drive_ready();
      @(negedge clk);
   endtask

   // Present one beat from a negedge until accepted; returns on a negedge.
   task automatic send_beat(input bit is_pld, input beat_t b);
      int budget;
      bit taken;
      if (gaps && $urandom_range(0, 3) == 0) idle();
      drive_ready();
      aad_valid = !is_pld;
      pld_valid = is_pld;
      aad_data = b.data; aad_keep = b.keep; aad_last = b.last;
      pld_data = b.data; pld_keep = b.keep; pld_last = b.last;
      budget = 100;
      forever begin
         #4;
         taken = is_pld ? pld_ready : aad_ready;
         @(negedge clk);
         if (taken) break;
         budget--;
         if (budget == 0) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout: got no ready expected accept");
            break;
         end
         drive_ready();
      end
   endtask

   task automatic pulse_start(input bit algo);
      exp_q.delete();
      stall_cnt = 0;
      start = 1'b1;
      algo_sel = algo;
      aad_valid = 1'b0;
      pld_valid = 1'b0;
      blk_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_msg(input bit algo, input int an, input int pn,
                          input int abad, input int pbad, input int mode);
      beat_q_t          abq, pbq;
      byte_q_t          aby, pby;
      logic [LEN_W-1:0] a_exp, p_exp;
      bit               e_err;
      bit               seen;
      blk_t             e;
      gen_section(an, abad, abq, aby);
      gen_section(pn, pbad, pbq, pby);
      pulse_start(algo);
      rdy_mode = mode;
      push_blocks(aby, 2'd0);
      push_blocks(pby, 2'd1);
      a_exp = LEN_W'(aby.size());
      p_exp = LEN_W'(pby.size());
      e.data = len_model(algo, a_exp, p_exp);
      e.kind = 2'd2;
      e.last = 1'b1;
      exp_q.push_back(e);
      e_err = (abad >= 0) || (pbad >= 0) || (aby.size() >= (1 << LEN_W)) || (pby.size() >= (1 << LEN_W));
      foreach (abq[i]) send_beat(1'b0, abq[i]);
      foreach (pbq[i]) send_beat(1'b1, pbq[i]);
      aad_valid = 1'b0;
      pld_valid = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 200; k++) begin
         drive_ready();
         #4;
         if (done) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("done", done, 1'b1);
      chk("busy_after_done", busy, 1'b0);
      chk("aad_len", aad_len, a_exp);
      chk("pld_len", pld_len, p_exp);
      chk("err", err, e_err);
      chk("blocks_left", exp_q.size(), 0);
      chk("ready_in_done", {aad_ready, pld_ready}, 2'b00);
      if (seen) @(negedge clk);
   endtask

   // Compare process: every accepted block, stability while stalled, ready gating.
   initial begin
      bit           prev_stall, prev_start;
      logic [127:0] prev_data;
      logic [1:0]   prev_kind;
      logic         prev_last;
      blk_t         e;
      prev_stall = 1'b0;
      prev_start = 1'b0;
      prev_data = '0;
      prev_kind = '0;
      prev_last = 1'b0;
      forever begin
         @(negedge clk);
         #3;
         if (rst_n === 1'b1) begin
            if (prev_stall && !prev_start) begin
               chk("hold_valid", blk_valid, 1'b1);
               chk("hold_data", blk_data, prev_data);
               chk("hold_kind", blk_kind, prev_kind);
               chk("hold_last", blk_last, prev_last);
            end
            if (blk_valid && !blk_ready) chk("ready_while_stalled", {aad_ready, pld_ready}, 2'b00);
            if (blk_valid && blk_ready && !start) begin
               blk_count++;
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_block: got %0h expected none", blk_data);
               end else begin
                  e = exp_q.pop_front();
                  chk("blk_data", blk_data, e.data);
                  chk("blk_kind", blk_kind, e.kind);
                  chk("blk_last", blk_last, e.last);
               end
               if (blk_last) last_len = blk_data;
            end
            prev_stall = blk_valid && !blk_ready;
            prev_start = start;
            prev_data  = blk_data;
            prev_kind  = blk_kind;
            prev_last  = blk_last;
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int      bc0;
      int      abad, pbad;
      beat_q_t abq;
      byte_q_t aby, pby;
      beat_t   bt;
      rst_n = 1'b0;
      start = 1'b0; algo_sel = 1'b0;
      aad_valid = 1'b1; aad_data = '0; aad_keep = '1; aad_last = 1'b0;
      pld_valid = 1'b1; pld_data = '0; pld_keep = '1; pld_last = 1'b0;
      blk_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #4;
      chk("rst_blk_valid", blk_valid, 1'b0);
      chk("rst_blk_data", blk_data, 128'd0);
      chk("rst_blk_kind_last", {blk_kind, blk_last}, 3'd0);
      chk("rst_lens", {aad_len, pld_len}, 32'd0);
      chk("rst_status", {busy, done, err}, 3'b000);
      chk("idle_ready", {aad_ready, pld_ready}, 2'b00);
      @(negedge clk);
      aad_valid = 1'b0;
      pld_valid = 1'b0;

      // T1: ChaCha layout, 12 B AAD + 32 B payload -> 4 blocks
      bc0 = blk_count;
      run_msg(1'b1, 12, 32, -1, -1, 0);
      chk("t1_nblk", blk_count - bc0, 4);
      chk("t1_len", last_len, {64'd32, 64'd12});

      // T2: GCM layout, bit lengths big-endian
      run_msg(1'b0, 12, 32, -1, -1, 1);
      chk("t2_len", last_len, 128'h0001_0000_0000_0000_6000_0000_0000_0000);

      // T3: empty sections -> only the LEN block
      bc0 = blk_count;
      run_msg(1'b1, 0, 0, -1, -1, 1);
      chk("t3_nblk", blk_count - bc0, 1);
      chk("t3_len", last_len, 128'd0);

      // T4: 20 B payload, first block stalled three cycles
      bc0 = blk_count;
      gaps = 1'b0;
      run_msg(1'b1, 0, 20, -1, -1, 2);
      chk("t4_nblk", blk_count - bc0, 3);

      // T6: bad keep on a non-last AAD beat, then cleared by start
      run_msg(1'b1, 8, 8, 3, -1, 0);
      pulse_start(1'b0);
      #4;
      chk("t6_err_cleared", err, 1'b0);
      chk("t6_busy", busy, 1'b1);
      @(negedge clk);

      // T5: start while a payload block is pending
      gen_section(4, -1, abq, aby);
      pby = {};
      for (int i = 0; i < 16; i++) pby.push_back(8'($urandom));
      pulse_start(1'b1);
      rdy_mode = 0;
      push_blocks(aby, 2'd0);
      push_blocks(pby, 2'd1);
      foreach (abq[i]) send_beat(1'b0, abq[i]);
      for (int f = 0; f < 4; f++) begin
         if (f == 3) rdy_mode = 3;
         bt = {pby[4*f+3], pby[4*f+2], pby[4*f+1], pby[4*f], 4'hF, 1'b0};
         send_beat(1'b1, bt);
      end
      exp_q.delete();
      start = 1'b1;
      blk_ready = 1'b0;
      pld_valid = 1'b1; pld_data = 32'($urandom); pld_keep = 4'hF; pld_last = 1'b0;
      #4;
      chk("t5_pending", blk_valid, 1'b1);
      chk("t5_start_cycle_ready", pld_ready, 1'b0);
      @(negedge clk);
      start = 1'b0;
      pld_valid = 1'b0;
      #4;
      chk("t5_valid_dropped", blk_valid, 1'b0);
      chk("t5_lens", {aad_len, pld_len}, 32'd0);
      chk("t5_in_aad", {busy, aad_ready, pld_ready}, 3'b110);
      @(negedge clk);
      run_msg(1'b1, 12, 32, -1, -1, 0);
      chk("t5_followup_len", last_len, {64'd32, 64'd12});

      // Randomized messages, with occasional protocol errors
      gaps = 1'b1;
      for (int it = 0; it < 30; it++) begin
         abad = -1;
         pbad = -1;
         if ($urandom_range(0, 5) == 0) abad = $urandom_range(0, 1) ? 5 : $urandom_range(0, 7);
         if ($urandom_range(0, 5) == 0) pbad = $urandom_range(0, 1) ? 10 : $urandom_range(0, 7);
         run_msg(1'($urandom), $urandom_range(0, 40), $urandom_range(0, 40), abad, pbad, $urandom_range(0, 2));
      end

      // Counter wrap: exactly 2^LEN_W AAD bytes
      gaps = 1'b0;
      run_msg(1'b0, 1 << LEN_W, 5, -1, -1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
